interrupt_dispatcher: RTL and testbench

INTERRUPT_DISPATCHER -- requirements
Module: interrupt_dispatcher

---
 rtl/interrupt_dispatcher_if.sv | 24 ++
 rtl/interrupt_dispatcher.sv | 143 ++++++++++++++
 tb/tb_interrupt_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_dispatcher_if.sv
// Shared word type and the register-bus interface of interrupt_dispatcher.
// The CPU side drives the bus (master); the dispatcher answers it (slave).
package interrupt_dispatcher_pkg;
  typedef logic [31:0] word_t;
endpackage

interface interrupt_dispatcher_if;
  logic                          chip_select_i;
  logic [3:0]                    addr_i;
  logic                          read_enable_i;
  interrupt_dispatcher_pkg::word_t read_data_o;
  interrupt_dispatcher_pkg::word_t write_data_i;
  logic [3:0]                    write_mask_i;

  modport master (
    output chip_select_i, addr_i, read_enable_i, write_data_i, write_mask_i,
    input  read_data_o
  );

  modport slave (
    input  chip_select_i, addr_i, read_enable_i, write_data_i, write_mask_i,
    output read_data_o
  );
endinterface

// File: rtl/interrupt_dispatcher.sv
// 32-source interrupt dispatcher: pending/enable bookkeeping, fixed lowest-index
// priority, and a claim/complete handshake with a single source in service.
module interrupt_dispatcher
  import interrupt_dispatcher_pkg::*;
#(
  parameter word_t EDGE_MASK = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  word_t                interrupt_i,
  output logic                 interrupt_o,
  interrupt_dispatcher_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_e;

  localparam logic [3:0] ADDR_PENDING    = 4'h0;
  localparam logic [3:0] ADDR_ENABLED    = 4'h1;
  localparam logic [3:0] ADDR_CLAIM      = 4'h2;
  localparam logic [3:0] ADDR_IN_SERVICE = 4'h3;

  state_e     state_q, state_d;
  word_t      src_q, src_prev_q;
  word_t      pending_q, pending_d;
  word_t      enabled_q, enabled_d;
  word_t      in_service_q, in_service_d;
  word_t      read_data_q, read_data_d;
  logic [5:0] svc_id_q, svc_id_d;
  logic       irq_q, irq_d;

  word_t      req, set_vec, claim_mask;
  logic       cand_valid;
  logic [4:0] cand_idx;
  logic [5:0] cand_id;
  logic       rd_en, wr_en, claim_rd, do_claim, do_complete;

  // Lowest index wins, so scan from the top and let later hits overwrite.
  always_comb begin
    req        = pending_q & enabled_q;
    cand_valid = |req;
    cand_idx   = '0;
    for (int i = 31; i >= 0; i--) begin
      if (req[i]) cand_idx = 5'(i);
    end
  end

  assign cand_id     = {1'b0, cand_idx} + 6'd1;
  assign rd_en       = bus.chip_select_i & bus.read_enable_i;
  assign wr_en       = bus.chip_select_i & (|bus.write_mask_i);
  assign claim_rd    = rd_en && (bus.addr_i == ADDR_CLAIM);
  assign do_claim    = claim_rd && (state_q == ASSERT) && cand_valid;
  assign do_complete = wr_en && (bus.addr_i == ADDR_CLAIM) && bus.write_mask_i[0]
                       && (state_q == SERVICE) && (bus.write_data_i[5:0] == svc_id_q);
  assign set_vec     = src_q & ~in_service_q & (~EDGE_MASK | ~src_prev_q);
  assign claim_mask  = do_claim ? (word_t'(1) << cand_idx) : '0;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    pending_d    = pending_q;
    enabled_d    = enabled_q;
    in_service_d = in_service_q;
    read_data_d  = read_data_q;
    svc_id_d     = svc_id_q;

    // A fresh edge on the claimed source survives the claim; a held level does not.
    pending_d = (pending_q & ~claim_mask) | (set_vec & ~(claim_mask & ~EDGE_MASK));

    if (wr_en && (bus.addr_i == ADDR_ENABLED)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.write_mask_i[b]) enabled_d[8*b +: 8] = bus.write_data_i[8*b +: 8];
      end
    end

    if (rd_en) begin
      case (bus.addr_i)
        ADDR_PENDING:    read_data_d = pending_q;
        ADDR_ENABLED:    read_data_d = enabled_q;
        ADDR_CLAIM:      read_data_d = do_claim ? word_t'(cand_id) : '0;
        ADDR_IN_SERVICE: read_data_d = in_service_q;
        default:         read_data_d = '0;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (cand_valid) state_d = ASSERT;
      end
      ASSERT: begin
        if (!cand_valid) begin
          state_d = IDLE;
        end else if (claim_rd) begin
          state_d      = SERVICE;
          in_service_d = claim_mask;
          svc_id_d     = cand_id;
        end
      end
      SERVICE: begin
        if (do_complete) begin
          state_d      = IDLE;
          in_service_d = '0;
          svc_id_d     = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    irq_d = (state_d == ASSERT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      src_q        <= '0;
      src_prev_q   <= '0;
      pending_q    <= '0;
      enabled_q    <= '0;
      in_service_q <= '0;
      read_data_q  <= '0;
      svc_id_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking so src_prev_q captures the old src_q, not this edge's sample.
      state_q      <= state_d;
      src_q        <= interrupt_i;
      src_prev_q   <= src_q;
      pending_q    <= pending_d;
      enabled_q    <= enabled_d;
      in_service_q <= in_service_d;
      read_data_q  <= read_data_d;
      svc_id_q     <= svc_id_d;
      irq_q        <= irq_d;
    end
  end

  assign interrupt_o     = irq_q;
  assign bus.read_data_o = read_data_q;

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// Self-checking bench for interrupt_dispatcher: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_interrupt_dispatcher;

  localparam logic [31:0] EDGE = 32'hF0F0_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] interrupt_i = '0;
  logic        interrupt_o;
  int          checks = 0;
  int          errors = 0;

  interrupt_dispatcher_if bus ();

  interrupt_dispatcher #(.EDGE_MASK(EDGE)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .interrupt_i (interrupt_i),
    .interrupt_o (interrupt_o),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Reference model: the source in service is an ID (0 = none) and the CPU
  // line is a plain bit; priority is a search over pending & enabled.
  logic [31:0] m_src, m_prev, m_pend, m_en, m_rdata;
  int          m_svc;
  bit          m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_src = '0; m_prev = '0; m_pend = '0; m_en = '0; m_rdata = '0;
    m_svc = 0;  m_irq = 1'b0;
  endtask

  task automatic model_clock();
    int          cand, svc_n;
    bit          rd, wr, claim, complete, irq_n;
    logic [31:0] set_v, pend_n, en_n, rdata_n;
    cand = -1;
    for (int i = 0; i < 32; i++) begin
      if (m_pend[i] && m_en[i]) begin
        cand = i;
        break;
      end
    end
    rd       = bus.chip_select_i && bus.read_enable_i;
    wr       = bus.chip_select_i && (bus.write_mask_i != 4'h0);
    claim    = rd && bus.addr_i == 4'h2 && m_irq && cand >= 0;
    complete = wr && bus.addr_i == 4'h2 && bus.write_mask_i[0] && m_svc != 0
               && int'(bus.write_data_i[5:0]) == m_svc;
    rdata_n = m_rdata;
    if (rd) begin
      case (bus.addr_i)
        4'h0:    rdata_n = m_pend;
        4'h1:    rdata_n = m_en;
        4'h2:    rdata_n = claim ? 32'(cand + 1) : 32'h0;
        4'h3:    rdata_n = (m_svc != 0) ? (32'h1 << (m_svc - 1)) : 32'h0;
        default: rdata_n = 32'h0;
      endcase
    end
    for (int i = 0; i < 32; i++)
      set_v[i] = m_src[i] && (m_svc != i + 1) && (!EDGE[i] || !m_prev[i]);
    pend_n = m_pend | set_v;
    if (claim) pend_n[cand] = EDGE[cand] && set_v[cand];
    en_n = m_en;
    if (wr && bus.addr_i == 4'h1)
      for (int b = 0; b < 4; b++)
        if (bus.write_mask_i[b]) en_n[8*b +: 8] = bus.write_data_i[8*b +: 8];
    svc_n = m_svc;
    if (m_svc != 0) begin
      irq_n = 1'b0;
      if (complete) svc_n = 0;
    end else if (m_irq) begin
      irq_n = (cand >= 0) && !claim;
      if (claim) svc_n = cand + 1;
    end else begin
      irq_n = (cand >= 0);
    end
    m_prev = m_src; m_src = interrupt_i; m_pend = pend_n; m_en = en_n;
    m_rdata = rdata_n; m_svc = svc_n; m_irq = irq_n;
  endtask

  task automatic bus_idle();
    bus.chip_select_i = 1'b0; bus.read_enable_i = 1'b0; bus.addr_i = '0;
    bus.write_data_i  = '0;   bus.write_mask_i  = '0;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
    check("irq", interrupt_o, 32'(m_irq));
    check("rdata", bus.read_data_o, m_rdata);
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus.chip_select_i = 1'b1; bus.read_enable_i = 1'b1; bus.addr_i = a;
    step();
    d = bus.read_data_o;
    bus_idle();
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    bus.chip_select_i = 1'b1; bus.addr_i = a; bus.write_data_i = d; bus.write_mask_i = m;
    step();
    bus_idle();
  endtask

  task automatic bus_rw(input logic [3:0] a, input logic [31:0] wd, input logic [3:0] m,
                        output logic [31:0] d);
    bus.chip_select_i = 1'b1; bus.read_enable_i = 1'b1; bus.addr_i = a;
    bus.write_data_i  = wd;   bus.write_mask_i  = m;
    step();
    d = bus.read_data_o;
    bus_idle();
  endtask

  task automatic wait_irq(input int budget, input string tag);
    int n = 0;
    while (interrupt_o !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, interrupt_o, 32'h1);
  endtask

  // Reset lands mid-cycle and outputs are sampled before the next edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check({tag, "_irq"}, interrupt_o, 32'h0);
    check({tag, "_rdata"}, bus.read_data_o, 32'h0);
    interrupt_i = '0;
    bus_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int          op;
    bus_idle();
    model_reset();
    #1;
    do_reset("por");

    // Byte-masked ENABLED and read-before-write on the same address.
    bus_rw(4'h1, 32'hDEAD_BEEF, 4'hF, d);
    check("rw_old_value", d, 32'h0);
    bus_write(4'h1, 32'h1122_3344, 4'b0101);
    bus_read(4'h1, d);
    check("byte_mask", d, 32'hDE22_BE44);
    bus_read(4'h7, d);
    check("unmapped", d, 32'h0);

    // Single level source, claim, in-service readback, complete.
    do_reset("s1");
    bus_write(4'h1, 32'h3, 4'hF);
    interrupt_i[1] = 1'b1;
    wait_irq(3, "level_irq_3cyc");
    bus_read(4'h2, d);
    check("claim_id2", d, 32'h2);
    check("irq_low_after_claim", interrupt_o, 32'h0);
    bus_read(4'h3, d);
    check("in_service_2", d, 32'h2);
    interrupt_i = '0;
    bus_write(4'h2, 32'h2, 4'h1);
    step();
    check("idle_after_complete", interrupt_o, 32'h0);

    // Priority between sources 5 and 9.
    do_reset("s2");
    bus_write(4'h1, 32'h0000_0220, 4'hF);
    interrupt_i = (32'h1 << 5) | (32'h1 << 9);
    wait_irq(4, "prio_irq");
    bus_read(4'h2, d);
    check("claim_id6", d, 32'h6);
    interrupt_i = 32'h1 << 9;
    bus_write(4'h2, 32'h6, 4'h1);
    wait_irq(4, "prio_reassert");
    bus_read(4'h2, d);
    check("claim_id10", d, 32'hA);

    // Edge source 4: a pulse latches; a pulse during service is dropped.
    do_reset("s3");
    bus_write(4'h1, 32'h10, 4'hF);
    interrupt_i = 32'h10; step();
    interrupt_i = '0;     step(); step();
    bus_read(4'h0, d);
    check("edge_latched", d, 32'h10);
    wait_irq(4, "edge_irq");
    bus_read(4'h2, d);
    check("claim_id5", d, 32'h5);
    interrupt_i = 32'h10; step();
    interrupt_i = '0;     step(); step();
    bus_read(4'h0, d);
    check("edge_ignored_in_service", d, 32'h0);
    bus_write(4'h2, 32'h5, 4'h1);
    step();
    check("edge_done_irq", interrupt_o, 32'h0);

    // Wrong completion ID is ignored.
    do_reset("s4");
    bus_write(4'h1, 32'h4, 4'hF);
    interrupt_i = 32'h4;
    wait_irq(4, "svc3_irq");
    bus_read(4'h2, d);
    check("claim_id3", d, 32'h3);
    interrupt_i = '0;
    bus_write(4'h2, 32'h7, 4'h1);
    bus_read(4'h3, d);
    check("bad_complete_kept", d, 32'h4);
    check("bad_complete_irq", interrupt_o, 32'h0);
    bus_write(4'h2, 32'h3, 4'h1);
    bus_read(4'h3, d);
    check("good_complete", d, 32'h0);

    // Withdrawing the enable while asserting.
    do_reset("s5");
    bus_write(4'h1, 32'h1, 4'hF);
    interrupt_i = 32'h1;
    wait_irq(4, "enable_irq");
    bus_write(4'h1, 32'h0, 4'hF);
    step();
    check("irq_dropped", interrupt_o, 32'h0);
    bus_read(4'h2, d);
    check("claim_when_idle", d, 32'h0);

    // Asynchronous reset in the middle of a service.
    do_reset("s6");
    bus_write(4'h1, 32'h8, 4'hF);
    interrupt_i = 32'h8;
    wait_irq(4, "svc4_irq");
    bus_read(4'h2, d);
    check("claim_id4", d, 32'h4);
    bus_read(4'h3, d);
    check("in_service_8", d, 32'h8);
    do_reset("mid_service");
    bus_read(4'h1, d);
    check("enabled_cleared", d, 32'h0);
    bus_read(4'h3, d);
    check("in_service_cleared", d, 32'h0);
    bus_read(4'h0, d);
    check("pending_cleared", d, 32'h0);
    bus_write(4'h1, 32'h8, 4'hF);
    interrupt_i = 32'h8;
    wait_irq(4, "repend_after_reset");
    bus_read(4'h2, d);
    check("reclaim_id4", d, 32'h4);

    // Randomized traffic against the model.
    do_reset("rand");
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 63) == 0) interrupt_i = '0;
      else if ($urandom_range(0, 3) == 0) interrupt_i = interrupt_i ^ (32'h1 << $urandom_range(0, 31));
      op = $urandom_range(0, 9);
      case (op)
        4: begin
          bus.chip_select_i = ($urandom_range(0, 7) != 0);
          bus.read_enable_i = 1'b1;
          bus.addr_i        = 4'($urandom_range(0, 15));
        end
        5, 6: begin
          bus.chip_select_i = 1'b1; bus.read_enable_i = 1'b1; bus.addr_i = 4'h2;
        end
        7: begin
          bus.chip_select_i = 1'b1; bus.addr_i = 4'h2;
          bus.write_data_i  = $urandom_range(0, 1) ? 32'(m_svc) : 32'($urandom_range(0, 63));
          bus.write_mask_i  = ($urandom_range(0, 3) == 0) ? 4'b1110 : 4'hF;
        end
        8: begin
          bus.chip_select_i = 1'b1; bus.addr_i = 4'h1;
          bus.write_data_i  = $urandom & $urandom;
          bus.write_mask_i  = 4'($urandom_range(1, 15));
        end
        9: begin
          bus.chip_select_i = 1'b1; bus.read_enable_i = 1'b1;
          bus.addr_i        = 4'($urandom_range(0, 3));
          bus.write_data_i  = $urandom;
          bus.write_mask_i  = 4'($urandom_range(1, 15));
        end
        default: bus_idle();
      endcase
      step();
      bus_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
